// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access-type codes, arbiter state
// constants and the alignment rule used by both requester ports.
package dm_arbiter_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    localparam logic [0:0] ARB_NORM  = 1'b0;
    localparam logic [0:0] ARB_FORCE = 1'b1;

    // Unknown type codes are treated as byte-wide (never flagged).
    function automatic logic dm_is_aligned(input logic [2:0] acc_type, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b1;
        case (acc_type)
            DM_WORD:                           ok = (addr_lo == 2'b00);
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: ok = ~addr_lo[0];
            default:                           ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dm_align_chk.sv
// Alignment check for one requester port: combinational, zero latency, no backpressure.
module dm_align_chk
    import dm_arbiter_pkg::*;
(
    input  logic [2:0] acc_type,
    input  logic [1:0] addr_lo,
    output logic       aligned
);

    assign aligned = dm_is_aligned(acc_type, addr_lo);

endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA arbiter in front of the single-ported data memory.
// Latency: grant and memory mux are combinational; DMA read data and error flags one cycle later.
// Backpressure: CPU is stalled on a lost cycle; DMA holds its request until dma_gnt.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_type,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [2:0]  dma_type,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_wr,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_dout,
    output logic        mis_err,
    output logic [31:0] mis_addr
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cpu_gnt, dma_gnt_int;
    logic             cpu_aligned, dma_aligned;
    logic             gnt_mis;
    logic [31:0]      gnt_addr;

    dm_align_chk u_cpu_align (.acc_type(cpu_type), .addr_lo(cpu_addr[1:0]), .aligned(cpu_aligned));
    dm_align_chk u_dma_align (.acc_type(dma_type), .addr_lo(dma_addr[1:0]), .aligned(dma_aligned));

    assign cpu_gnt     = cpu_req && ((state == ARB_NORM) || !dma_req);
    assign dma_gnt_int = dma_req && !cpu_gnt;
    assign dma_gnt     = dma_gnt_int;
    assign cpu_stall   = cpu_req && !cpu_gnt;
    assign cpu_rdata   = mem_dout;

    always_comb begin
        mem_wr   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        mem_type = '0;
        mem_pc   = '0;
        gnt_mis  = 1'b0;
        gnt_addr = '0;
        if (cpu_gnt) begin
            mem_wr   = cpu_wr && cpu_aligned && rstn;
            mem_addr = cpu_addr[31:2];
            mem_din  = cpu_wdata;
            mem_type = cpu_type;
            mem_pc   = cpu_pc;
            gnt_mis  = !cpu_aligned;
            gnt_addr = cpu_addr;
        end else if (dma_gnt_int) begin
            mem_wr   = dma_wr && dma_aligned && rstn;
            mem_addr = dma_addr[31:2];
            mem_din  = dma_wdata;
            mem_type = dma_type;
            gnt_mis  = !dma_aligned;
            gnt_addr = dma_addr;
        end
    end

    // Count only cycles the DMA port actually waited behind the CPU.
    always_comb begin
        cnt_nxt = cnt;
        if (dma_gnt_int || !dma_req)
            cnt_nxt = '0;
        else if (cpu_gnt)
            cnt_nxt = cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_NORM:  if (cnt_nxt == STARVE_LIM) state_nxt = ARB_FORCE;
            ARB_FORCE: if (dma_gnt_int || !dma_req) state_nxt = ARB_NORM;
            default:   state_nxt = ARB_NORM;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ARB_NORM;
            cnt        <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            mis_err    <= 1'b0;
            mis_addr   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dma_rvalid <= dma_gnt_int && !dma_wr;
            if (dma_gnt_int && !dma_wr)
                dma_rdata <= mem_dout;
            mis_err <= gnt_mis;
            if (gnt_mis)
                mis_addr <= gnt_addr;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small word-array memory model behind it.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc, cpu_rdata;
    logic [2:0]  cpu_type;
    logic        cpu_stall;
    logic        dma_req, dma_wr, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [2:0]  dma_type;
    logic        mem_wr;
    logic [29:0] mem_addr;
    logic [31:0] mem_din, mem_pc, mem_dout;
    logic [2:0]  mem_type;
    logic        mis_err;
    logic [31:0] mis_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:63];

    dm_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_type(cpu_type), .cpu_pc(cpu_pc), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_type(dma_type), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_type(mem_type),
        .mem_pc(mem_pc), .mem_dout(mem_dout), .mis_err(mis_err), .mis_addr(mis_addr)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr[5:0]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[5:0]] <= mem_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] typ);
        cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_type = typ;
    endtask

    task automatic set_dma(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] typ);
        dma_req = req; dma_wr = wr; dma_addr = addr; dma_wdata = wdata; dma_type = typ;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rstn = 1'b0;
        cpu_pc = 32'h0000_0100;
        set_cpu(0, 0, 0, 0, 3'b000);
        set_dma(0, 0, 0, 0, 3'b000);
        #1;
        chk("rst_stall",   {31'b0, cpu_stall},  32'd0);
        chk("rst_gnt",     {31'b0, dma_gnt},    32'd0);
        chk("rst_mem_wr",  {31'b0, mem_wr},     32'd0);
        chk("rst_addr",    {2'b0, mem_addr},    32'd0);
        chk("rst_rvalid",  {31'b0, dma_rvalid}, 32'd0);
        chk("rst_rdata",   dma_rdata,           32'd0);
        chk("rst_mis_err", {31'b0, mis_err},    32'd0);
        chk("rst_mis_adr", mis_addr,            32'd0);

        // CPU-only word store
        @(negedge clk);
        rstn = 1'b1;
        set_cpu(1, 1, 32'h40, 32'h1234_5678, 3'b000);
        #1;
        chk("st_mem_wr", {31'b0, mem_wr},    32'd1);
        chk("st_addr",   {2'b0, mem_addr},   32'h10);
        chk("st_din",    mem_din,            32'h1234_5678);
        chk("st_pc",     mem_pc,             32'h100);
        chk("st_stall",  {31'b0, cpu_stall}, 32'd0);
        chk("st_gnt",    {31'b0, dma_gnt},   32'd0);

        // DMA-only read
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 3'b000);
        set_dma(1, 0, 32'h40, 0, 3'b000);
        #1;
        chk("dr_gnt",    {31'b0, dma_gnt},    32'd1);
        chk("dr_mem_wr", {31'b0, mem_wr},     32'd0);
        chk("dr_addr",   {2'b0, mem_addr},    32'h10);
        chk("dr_pc",     mem_pc,              32'd0);
        chk("dr_rv0",    {31'b0, dma_rvalid}, 32'd0);

        @(negedge clk);
        set_dma(0, 0, 0, 0, 3'b000);
        set_cpu(1, 0, 32'h40, 0, 3'b000);
        #1;
        chk("dr_rv1",    {31'b0, dma_rvalid}, 32'd1);
        chk("dr_rdata",  dma_rdata,           32'h1234_5678);
        chk("ld_rdata",  cpu_rdata,           32'h1234_5678);
        chk("ld_stall",  {31'b0, cpu_stall},  32'd0);

        @(negedge clk);
        set_cpu(0, 0, 0, 0, 3'b000);
        #1;
        chk("idle_rv",   {31'b0, dma_rvalid}, 32'd0);
        chk("idle_addr", {2'b0, mem_addr},    32'd0);

        // Continuous contention: DMA gets every fifth slot
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_cpu(1, 0, 32'h44, 0, 3'b000);
            set_dma(1, 0, 32'h40, 0, 3'b000);
            #1;
            chk($sformatf("ct_stall%0d", i), {31'b0, cpu_stall},  (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("ct_gnt%0d", i),   {31'b0, dma_gnt},    (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("ct_addr%0d", i),  {2'b0, mem_addr},    (i % 5 == 4) ? 32'h10 : 32'h11);
            chk($sformatf("ct_rv%0d", i),    {31'b0, dma_rvalid}, (i == 5) ? 32'd1 : 32'd0);
        end

        // Misaligned word store, then aligned halfword at the same address
        @(negedge clk);
        set_dma(0, 0, 0, 0, 3'b000);
        set_cpu(1, 1, 32'h42, 32'h1234_5678, 3'b000);
        #1;
        chk("mw_mem_wr", {31'b0, mem_wr},     32'd0);
        chk("mw_stall",  {31'b0, cpu_stall},  32'd0);
        chk("mw_rv",     {31'b0, dma_rvalid}, 32'd1);

        @(negedge clk);
        set_cpu(1, 1, 32'h42, 32'h1234_5678, 3'b001);
        #1;
        chk("hw_mem_wr", {31'b0, mem_wr},  32'd1);
        chk("mw_err",    {31'b0, mis_err}, 32'd1);
        chk("mw_maddr",  mis_addr,         32'h42);

        @(negedge clk);
        set_cpu(1, 0, 32'h43, 0, 3'b011);
        #1;
        chk("hw_err",    {31'b0, mis_err}, 32'd0);
        chk("bl_mem_wr", {31'b0, mem_wr},  32'd0);

        // Misaligned DMA read still returns data
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 3'b000);
        set_dma(1, 0, 32'h41, 0, 3'b000);
        #1;
        chk("bl_err",    {31'b0, mis_err}, 32'd0);
        chk("md_gnt",    {31'b0, dma_gnt}, 32'd1);

        @(negedge clk);
        set_dma(0, 0, 0, 0, 3'b000);
        #1;
        chk("md_rv",     {31'b0, dma_rvalid}, 32'd1);
        chk("md_rdata",  dma_rdata,           32'h1234_5678);
        chk("md_err",    {31'b0, mis_err},    32'd1);
        chk("md_maddr",  mis_addr,            32'h41);

        // Build starvation count to 3, then reset during a DMA write grant
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            set_cpu(1, 0, 32'h44, 0, 3'b000);
            set_dma(1, 1, 32'h80, 32'hCAFE_F00D, 3'b000);
            #1;
            chk($sformatf("pre_stall%0d", k), {31'b0, cpu_stall}, 32'd0);
        end
        @(negedge clk);
        set_cpu(0, 0, 0, 0, 3'b000);
        #1;
        chk("pr_gnt",    {31'b0, dma_gnt}, 32'd1);
        chk("pr_mem_wr", {31'b0, mem_wr},  32'd1);
        rstn = 1'b0;
        #1;
        chk("ir_mem_wr", {31'b0, mem_wr},     32'd0);
        chk("ir_rv",     {31'b0, dma_rvalid}, 32'd0);
        set_cpu(1, 0, 32'h44, 0, 3'b000);

        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rl_stall",  {31'b0, cpu_stall}, 32'd0);
        chk("rl_gnt",    {31'b0, dma_gnt},   32'd0);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rl_stall%0d", j), {31'b0, cpu_stall}, 32'd0);
        end
        @(negedge clk);
        #1;
        chk("rl_dgnt",   {31'b0, dma_gnt},   32'd1);
        chk("rl_dstall", {31'b0, cpu_stall}, 32'd1);
        chk("rl_dwr",    {31'b0, mem_wr},    32'd1);
        chk("rl_daddr",  {2'b0, mem_addr},   32'h20);

        // Reach ARB_FORCE, then drop the DMA request
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_dma(1, 0, 32'h40, 0, 3'b000);
            #1;
            chk($sformatf("fc_stall%0d", k), {31'b0, cpu_stall}, 32'd0);
        end
        @(negedge clk);
        set_dma(0, 0, 0, 0, 3'b000);
        #1;
        chk("fd_stall",  {31'b0, cpu_stall}, 32'd0);
        chk("fd_gnt",    {31'b0, dma_gnt},   32'd0);
        chk("fd_addr",   {2'b0, mem_addr},   32'h11);

        @(negedge clk);
        set_dma(1, 0, 32'h40, 0, 3'b000);
        #1;
        chk("fn_stall",  {31'b0, cpu_stall},  32'd0);
        chk("fn_gnt",    {31'b0, dma_gnt},    32'd0);
        chk("fn_rv",     {31'b0, dma_rvalid}, 32'd0);

        @(negedge clk);
        set_cpu(0, 0, 0, 0, 3'b000);
        set_dma(0, 0, 0, 0, 3'b000);
        #1;
        chk("end_rv",    {31'b0, dma_rvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-requester arbiter in front of the single-ported data memory. Requesters are the pipeline MEM stage (CPU port) and a secondary DMA/loader port.
- Grants at most one access per cycle.
- Stalls the CPU when it loses arbitration.
- Guarantees the DMA port forward progress with a starvation counter.
- Suppresses misaligned accesses and flags them.
- Drives the memory's write enable, word address, write data, access type and PC-for-trace inputs.

Parameters:
STARVE_MAX, 4, max consecutive CPU grants while DMA is waiting before DMA is forced a slot (legal range 1..15)
CNT_W, 4, width of starvation counter; must satisfy 2^CNT_W > STARVE_MAX

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request (MEM stage load or store)
cpu_wr  in  1  1=store, 0=load
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU store data
cpu_type  in  3  access type, dm_* codes from ctrl_encode_def.v
cpu_pc  in  32  PC of the MEM-stage instruction, forwarded for write trace
cpu_rdata  out  32  load data, combinational, valid when cpu_req && !cpu_stall
cpu_stall  out  1  CPU lost arbitration this cycle; pipeline must hold
dma_req  in  1  DMA access request; held with stable payload until dma_gnt
dma_wr  in  1  1=write, 0=read
dma_addr  in  32  DMA byte address
dma_wdata  in  32  DMA write data
dma_type  in  3  access type, dm_* codes
dma_gnt  out  1  DMA access performed this cycle
dma_rdata  out  32  registered read data
dma_rvalid  out  1  one-cycle pulse: dma_rdata valid
mem_wr  out  1  to memory write enable
mem_addr  out  30  to memory word address (byte address bits 31:2)
mem_din  out  32  to memory write data
mem_type  out  3  to memory access type
mem_pc  out  32  to memory PC for trace (cpu_pc on CPU grant, 0 on DMA grant)
mem_dout  in  32  from memory combinational read data
mis_err  out  1  registered pulse: a granted access was misaligned
mis_addr  out  32  byte address of the last misaligned access

Behaviour:
- Reset (rstn low, async) clears all registered state:
  - starvation counter = 0; state = ARB_NORM
  - dma_rdata = 0, dma_rvalid = 0, mis_err = 0, mis_addr = 0
- Combinational outputs with no request: cpu_stall = 0, dma_gnt = 0, mem_wr = 0, mem_addr/mem_din/mem_type/mem_pc = 0.
- Reset asserted mid-transaction: no write is issued while rstn is low (mem_wr forced 0). A pending DMA request is re-arbitrated after release.
- States:
  - ARB_NORM: CPU wins if cpu_req; otherwise DMA wins if dma_req.
  - ARB_FORCE: DMA wins if dma_req; otherwise CPU.
- Counter:
  - Increments on every cycle where CPU is granted while dma_req=1.
  - Clears on any DMA grant, or on any cycle with dma_req=0.
  - When the count reaches STARVE_MAX, next state = ARB_FORCE.
  - ARB_FORCE returns to ARB_NORM after one DMA grant, or immediately if dma_req drops.
- cpu_stall = cpu_req && !cpu_granted. Grant decision is combinational in the same cycle; no added latency.
- Memory mux: the granted port drives mem_addr, mem_din, mem_type and mem_wr. mem_wr = granted wr && aligned.
- CPU loads: cpu_rdata = mem_dout in the grant cycle (zero-latency).
- DMA reads: dma_rdata captures mem_dout at the clock edge ending the grant cycle; dma_rvalid is high the following cycle. DMA writes produce no rvalid.
- Alignment rules:
  - Word access: byte address bits 1:0 must be 00.
  - Halfword (signed or unsigned): bit 0 must be 0.
  - Byte: always aligned.
- Misaligned granted access:
  - Write suppressed (mem_wr=0); the grant still counts (stall released, dma_gnt=1).
  - mis_err pulses next cycle; mis_addr latches the byte address.
  - A misaligned DMA read still produces dma_rvalid, with data = mem_dout.
- Both requests low: idle, counter cleared.
- cpu_req held while stalled: the CPU payload may change; arbitration re-evaluates each cycle.

Decomposition:
- Shared header ctrl_encode_def.v holds:
  - the dm_* access-type codes (already present);
  - new constants ARB_NORM and ARB_FORCE (1-bit state encoding).
- Alignment check is a natural sub-module, dm_align_chk (inputs: type, addr[1:0]; output: aligned). It is instantiated twice, once per port.

Test Plan:
- CPU-only store of word 0x12345678 to address 0x40 -> mem_wr=1, mem_addr=0x10, cpu_stall=0, dma_gnt=0.
- DMA-only read of address 0x40 -> dma_gnt=1 in cycle N; dma_rvalid=1 with dma_rdata=0x12345678 in cycle N+1.
- CPU and DMA both requesting continuously, STARVE_MAX=4 -> CPU granted 4 cycles, DMA granted 5th (cpu_stall=1 that cycle), pattern repeats.
- Word store to 0x42 -> mem_wr=0, mis_err=1 next cycle, mis_addr=0x42, no stall. Halfword store to 0x42 -> mem_wr=1.
- rstn driven low during a DMA grant with starvation count=3 -> immediately mem_wr=0, dma_rvalid=0, counter=0; after release CPU is granted first.
- dma_req dropped during ARB_FORCE -> state returns to ARB_NORM, CPU granted, no spurious dma_rvalid.
